bc_game_ctrl: RTL
=================

# bc_game_ctrl

Sequencing controller for the 4-digit bulls-and-cows comparator. It captures a secret code and successive guesses one digit at a time and drives the comparator's eight digit inputs and its `save` gate. It samples the comparator's per-position bull/cow flags, reduces them to counts, and tracks tries until a win or loss. It sits between the digit-entry front end (keypad or switches plus strobe) and the display logic.

## Interface
- `MAX_TRIES`, default 8: guesses allowed per game; legal range 1..15.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `new_game` in 1: one-cycle strobe; starts or restarts a game from any state.
- `digit_in` in 3: digit value 0..7.
- `digit_valid` in 1: one-cycle strobe qualifying `digit_in`.
- `secret_a/b/c/d` out 3 each: registered secret digits, to comparator `secret_number_*`.
- `guess_a/b/c/d` out 3 each: registered guess digits, to comparator `inp*`.
- `cmp_save` out 1: to comparator `save`; low only in EVAL.
- `bulls` in 4: per-position bull flags from the comparator.
- `cows` in 4: per-position cow flags from the comparator.
- `bull_cnt` out 3: bulls in the last evaluated guess, 0..4.
- `cow_cnt` out 3: cows in the last evaluated guess, 0..4.
- `tries` out 4: guesses evaluated this game.
- `result_valid` out 1: one-cycle pulse when `bull_cnt`/`cow_cnt` update.
- `win` out 1: sticky until `new_game`/`rst`.
- `lose` out 1: sticky until `new_game`/`rst`.
- `entering_secret` out 1: high in LOAD.
- `err` out 1: one-cycle pulse on a rejected digit (see Configuration).

## Operation
- States: IDLE, LOAD, GUESS, EVAL, RESULT, DONE.
- IDLE: ignores `digit_valid`. `new_game` -> LOAD.
- LOAD: each accepted digit is written to `secret_a`, `b`, `c`, `d` in order via a 2-bit position index. The 4th accepted digit -> GUESS, and the index resets to 0.
- GUESS: the same process writes `guess_a..d`. The 4th accepted digit -> EVAL.
- EVAL, one cycle:
  - `cmp_save`=0.
  - Register `bull_cnt` = popcount(`bulls`).
  - Register `cow_cnt` = popcount(`cows & ~bulls`). A position that is a bull is never also counted as a cow.
  - `tries` increments.
  - -> RESULT.
- RESULT, one cycle: `result_valid`=1.
  - If `bull_cnt`==4: set `win`, -> DONE.
  - Else if `tries`==MAX_TRIES: set `lose`, -> DONE.
  - Else -> GUESS.
  - Win takes priority on the final try.
- DONE: holds all outputs. Only `new_game` leaves the state.
- `new_game` in any state: -> LOAD; clears `secret_*`, `guess_*`, counts, `tries`, `win`, `lose`, and the index.
- Simultaneous `new_game` and `digit_valid`: `new_game` wins and the digit is dropped.
- `digit_valid` in EVAL, RESULT, DONE or IDLE is ignored. No buffering.
- `cmp_save`=1 in every state except EVAL, so the comparator outputs are forced to zero outside evaluation.

## Timing
- Reset values:
  - State IDLE.
  - All `secret_*`/`guess_*` = 0.
  - `bull_cnt`=`cow_cnt`=0, `tries`=0.
  - `win`=`lose`=`result_valid`=`err`=0.
  - `cmp_save`=1, `entering_secret`=0.
- `rst` mid-game aborts immediately to IDLE with the reset values above.
- A digit strobed in cycle N is visible on its `secret_*`/`guess_*` output in cycle N+1.
- 4th guess digit in cycle N:
  - EVAL during N+1, with `cmp_save`=0 and the comparator settled combinationally.
  - Counts, `tries` and `result_valid` visible in N+2.
  - `win`/`lose` visible in N+3.
- GUESS accepts the next digit from cycle N+3 at the earliest.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- `BC_UNIQUE_DIGITS_EN` defined:
  - In LOAD or GUESS, a digit equal to any digit already entered in the current 4-digit group is rejected.
  - A rejected digit is not stored and the index is unchanged.
  - `err` pulses the following cycle.
- Undefined: every strobed digit in LOAD/GUESS is accepted and `err` is tied to 0.

## Test plan
- Reset, `new_game`, secret 1,2,3,4, guess 1,2,3,4 -> `result_valid` 2 cycles after the 4th digit with `bull_cnt`=4, `cow_cnt`=0, `tries`=1; `win`=1 the next cycle; state DONE; later `digit_valid` ignored.
- Secret 1,2,3,4, guess 4,3,2,1 -> `bull_cnt`=0, `cow_cnt`=4. Then guess 1,3,2,4 -> `bull_cnt`=2, `cow_cnt`=2, `tries`=2.
- `MAX_TRIES`=3, secret 0,1,2,3, three guesses of 7,6,5,4 -> each gives 0/0; `lose`=1 after the 3rd; `tries`=3. A 4th on-try win case with bulls=4 sets `win`, not `lose`.
- `new_game` asserted with `digit_valid` while in GUESS after 2 digits -> digit dropped; state LOAD; `tries`=0; next digit lands in `secret_a`.
- `rst` during EVAL -> next cycle IDLE, `cmp_save`=1, all counts 0, `result_valid` never pulses.
- With `BC_UNIQUE_DIGITS_EN`: secret 5,5 -> second 5 rejected, `err` pulses, `secret_b` stays 0; then 6 is stored in `secret_b`. Without the macro: second 5 is stored and `err` stays 0.

Source files
------------

// File: rtl/bc_game_ctrl.sv
// bc_game_ctrl: bulls-and-cows sequencer feeding the digit comparator.
// Optional BC_UNIQUE_DIGITS_EN rejects repeated digits within a group.
module bc_game_ctrl #(
  parameter int MAX_TRIES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       new_game,
  input  logic [2:0] digit_in,
  input  logic       digit_valid,
  output logic [2:0] secret_a,
  output logic [2:0] secret_b,
  output logic [2:0] secret_c,
  output logic [2:0] secret_d,
  output logic [2:0] guess_a,
  output logic [2:0] guess_b,
  output logic [2:0] guess_c,
  output logic [2:0] guess_d,
  output logic       cmp_save,
  input  logic [3:0] bulls,
  input  logic [3:0] cows,
  output logic [2:0] bull_cnt,
  output logic [2:0] cow_cnt,
  output logic [3:0] tries,
  output logic       result_valid,
  output logic       win,
  output logic       lose,
  output logic       entering_secret,
  output logic       err
);

  typedef enum logic [2:0] {
    IDLE, LOAD, GUESS, EVAL, RESULT, DONE
  } state_t;

  state_t state, state_nx;

  logic [3:0][2:0] sec_q;
  logic [3:0][2:0] gss_q;
  logic [1:0]      idx;
  logic            entry;
  logic            dup;
  logic            accept;
  logic            reject;

  function automatic logic [2:0] cnt4(input logic [3:0] b);
    return 3'(b[0]) + 3'(b[1]) + 3'(b[2]) + 3'(b[3]);
  endfunction

  assign entry  = (state == LOAD) || (state == GUESS);
  assign accept = digit_valid && entry && !new_game && !dup;
  assign reject = digit_valid && entry && !new_game && dup;

`ifdef BC_UNIQUE_DIGITS_EN
  logic [3:0][2:0] grp;
  assign grp = (state == LOAD) ? sec_q : gss_q;

  // Flag a digit already present in the positions filled so far.
  always_comb begin
    dup = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if ((2'(i) < idx) && (grp[i] == digit_in)) dup = 1'b1;
    end
  end
`else
  assign dup = 1'b0;
`endif

  // Next-state decode; new_game overrides everything.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:   state_nx = IDLE;
      LOAD:   if (accept && idx == 2'd3) state_nx = GUESS;
      GUESS:  if (accept && idx == 2'd3) state_nx = EVAL;
      EVAL:   state_nx = RESULT;
      RESULT: begin
        if (bull_cnt == 3'd4)              state_nx = DONE;
        else if (tries == 4'(MAX_TRIES))   state_nx = DONE;
        else                               state_nx = GUESS;
      end
      DONE:   state_nx = DONE;
      default: state_nx = IDLE;
    endcase
    if (new_game) state_nx = LOAD;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Digit capture, count reduction, try tracking and win/lose flags.
  always_ff @(posedge clk) begin
    if (rst || new_game) begin
      sec_q    <= '0;
      gss_q    <= '0;
      idx      <= 2'd0;
      bull_cnt <= 3'd0;
      cow_cnt  <= 3'd0;
      tries    <= 4'd0;
      win      <= 1'b0;
      lose     <= 1'b0;
      err      <= 1'b0;
    end else begin
      err <= reject;
      if (accept) begin
        if (state == LOAD) sec_q[idx] <= digit_in;
        else               gss_q[idx] <= digit_in;
        idx <= idx + 2'd1;
      end
      if (state == EVAL) begin
        bull_cnt <= cnt4(bulls);
        cow_cnt  <= cnt4(cows & ~bulls);
        tries    <= tries + 4'd1;
      end
      if (state == RESULT) begin
        if (bull_cnt == 3'd4)            win  <= 1'b1;
        else if (tries == 4'(MAX_TRIES)) lose <= 1'b1;
      end
    end
  end

  assign secret_a = sec_q[0];
  assign secret_b = sec_q[1];
  assign secret_c = sec_q[2];
  assign secret_d = sec_q[3];
  assign guess_a  = gss_q[0];
  assign guess_b  = gss_q[1];
  assign guess_c  = gss_q[2];
  assign guess_d  = gss_q[3];

  assign cmp_save        = (state != EVAL);
  assign entering_secret = (state == LOAD);
  assign result_valid    = (state == RESULT);

endmodule
